// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared widths, encodings and pointer type for the write-back
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // PREF_A means B won last, so A wins the next tie.
    typedef enum logic [0:0] {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } rr_ptr_t;

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Requester handshakes and register-file write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int ADDR_W = wb_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = wb_port_arbiter_pkg::DATA_W
);
    logic              req_a;
    logic [ADDR_W-1:0] dest_a;
    logic [DATA_W-1:0] data_a;
    logic              grant_a;

    logic              req_b;
    logic [ADDR_W-1:0] dest_b;
    logic [DATA_W-1:0] data_b;
    logic              grant_b;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_sel;

    modport master (
        output req_a, dest_a, data_a,
        output req_b, dest_b, data_b,
        input  grant_a, grant_b,
        input  rf_we, rf_waddr, rf_wdata, rf_sel
    );

    modport slave (
        input  req_a, dest_a, data_a,
        input  req_b, dest_b, data_b,
        output grant_a, grant_b,
        output rf_we, rf_waddr, rf_wdata, rf_sel
    );

endinterface : wb_port_arbiter_if
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_pick
// Description : Combinational two-way round-robin grant selection.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_pick
    import wb_port_arbiter_pkg::*;
(
    input  wire logic    i_rst,
    input  wire logic    i_stall,
    input  wire logic    i_req_a,
    input  wire logic    i_req_b,
    input  wire rr_ptr_t i_ptr,
    output logic         o_grant_a,
    output logic         o_grant_b
);

    logic w_enable;

    assign w_enable  = !i_rst && !i_stall;
    assign o_grant_a = w_enable && i_req_a && (!i_req_b || (i_ptr == PREF_A));
    assign o_grant_b = w_enable && i_req_b && (!i_req_a || (i_ptr == PREF_B));

endmodule : wb_rr_pick
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Round-robin arbiter sharing one register-file write port
//               between the ALU path (A) and the multi-cycle unit (B).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = wb_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = wb_port_arbiter_pkg::DATA_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall,
    wb_port_arbiter_if.slave bus
);

    rr_ptr_t           r_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_sel;

    logic              w_grant_a;
    logic              w_grant_b;

    wb_rr_pick u_pick (
        .i_rst     (reset),
        .i_stall   (stall),
        .i_req_a   (bus.req_a),
        .i_req_b   (bus.req_b),
        .i_ptr     (r_ptr),
        .o_grant_a (w_grant_a),
        .o_grant_b (w_grant_b)
    );

    // A grant to $0 still moves the pointer but leaves the write port idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= PREF_A;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_sel   <= SEL_A;
        end else begin
            r_we <= 1'b0;
            if (w_grant_a) begin
                r_ptr <= PREF_B;
                if (bus.dest_a != ADDR_W'(ZERO_REG)) begin
                    r_we    <= 1'b1;
                    r_waddr <= bus.dest_a;
                    r_wdata <= bus.data_a;
                    r_sel   <= SEL_A;
                end
            end else if (w_grant_b) begin
                r_ptr <= PREF_A;
                if (bus.dest_b != ADDR_W'(ZERO_REG)) begin
                    r_we    <= 1'b1;
                    r_waddr <= bus.dest_b;
                    r_wdata <= bus.data_b;
                    r_sel   <= SEL_B;
                end
            end
        end
    end

    assign bus.grant_a  = w_grant_a;
    assign bus.grant_b  = w_grant_b;
    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.rf_sel   = r_sel;

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed table-driven bench for the write-back port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic clk;
    logic reset;
    logic stall;

    int n_checks;
    int n_errors;

    wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        ra;
        logic [4:0]  da;
        logic [31:0] wa;
        logic        rb;
        logic [4:0]  db;
        logic [31:0] wb;
        logic        ega;
        logic        egb;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic        esel;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic rst, input logic stl,
        input logic ra, input logic [4:0] da, input logic [31:0] wa,
        input logic rb, input logic [4:0] db, input logic [31:0] wb,
        input logic ega, input logic egb, input logic ewe,
        input logic [4:0] eaddr, input logic [31:0] edata, input logic esel);
        vec_t v;
        v.rst = rst; v.stl = stl;
        v.ra = ra; v.da = da; v.wa = wa;
        v.rb = rb; v.db = db; v.wb = wb;
        v.ega = ega; v.egb = egb; v.ewe = ewe;
        v.eaddr = eaddr; v.edata = edata; v.esel = esel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl,
                         input logic ra, input logic [4:0] da, input logic [31:0] wa,
                         input logic rb, input logic [4:0] db, input logic [31:0] wb);
        reset      = rst;
        stall      = stl;
        bus.req_a  = ra;
        bus.dest_a = da;
        bus.data_a = wa;
        bus.req_b  = rb;
        bus.dest_b = db;
        bus.data_b = wb;
    endtask

    // Grants are checked within the cycle; rf_* reflect the previous cycle's grant.
    task automatic expect_all(input string tag, input logic ga, input logic gb,
                              input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic sel);
        #1;
        chk({tag, " grant_a"},  32'(bus.grant_a),  32'(ga));
        chk({tag, " grant_b"},  32'(bus.grant_b),  32'(gb));
        chk({tag, " rf_we"},    32'(bus.rf_we),    32'(we));
        chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(addr));
        chk({tag, " rf_wdata"}, bus.rf_wdata,      data);
        chk({tag, " rf_sel"},   32'(bus.rf_sel),   32'(sel));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            rst stl ra da     wa          rb db     wb            ga gb we addr   data        sel
        tbl[0]  = mk(1, 0, 1, 5'd8, 32'hAA,     1, 5'd4, 32'h22,      0, 0, 0, 5'd0, 32'h0,     0);
        tbl[1]  = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd0, 32'h0,     0);
        tbl[2]  = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd0, 32'h0,     0);
        tbl[3]  = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd0, 32'h0,     0);
        tbl[4]  = mk(0, 0, 1, 5'd8, 32'hAA,     0, 5'd0, 32'h0,       1, 0, 0, 5'd0, 32'h0,     0);
        tbl[5]  = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 1, 5'd8, 32'hAA,    0);
        tbl[6]  = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd8, 32'hAA,    0);
        tbl[7]  = mk(1, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd8, 32'hAA,    0);
        tbl[8]  = mk(0, 0, 1, 5'd3, 32'h11,     1, 5'd4, 32'h22,      1, 0, 0, 5'd0, 32'h0,     0);
        tbl[9]  = mk(0, 0, 1, 5'd3, 32'h11,     1, 5'd4, 32'h22,      0, 1, 1, 5'd3, 32'h11,    0);
        tbl[10] = mk(0, 0, 1, 5'd3, 32'h11,     1, 5'd4, 32'h22,      1, 0, 1, 5'd4, 32'h22,    1);
        tbl[11] = mk(0, 0, 1, 5'd3, 32'h11,     1, 5'd4, 32'h22,      0, 1, 1, 5'd3, 32'h11,    0);
        tbl[12] = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 1, 5'd4, 32'h22,    1);
        tbl[13] = mk(0, 0, 1, 5'd5, 32'h55,     0, 5'd0, 32'h0,       1, 0, 0, 5'd4, 32'h22,    1);
        tbl[14] = mk(0, 0, 0, 5'd0, 32'h0,      1, 5'd0, 32'hDEAD,    0, 1, 1, 5'd5, 32'h55,    0);
        tbl[15] = mk(0, 0, 1, 5'd3, 32'h11,     1, 5'd4, 32'h22,      1, 0, 0, 5'd5, 32'h55,    0);
        tbl[16] = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 1, 5'd3, 32'h11,    0);
        tbl[17] = mk(0, 0, 0, 5'd0, 32'h0,      1, 5'd9, 32'h99,      0, 1, 0, 5'd3, 32'h11,    0);
        tbl[18] = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 1, 5'd9, 32'h99,    1);
        tbl[19] = mk(0, 0, 0, 5'd0, 32'h0,      0, 5'd0, 32'h0,       0, 0, 0, 5'd9, 32'h99,    1);

        drive(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].ra, tbl[i].da, tbl[i].wa,
                  tbl[i].rb, tbl[i].db, tbl[i].wb);
            expect_all($sformatf("vec%0d", i), tbl[i].ega, tbl[i].egb, tbl[i].ewe,
                       tbl[i].eaddr, tbl[i].edata, tbl[i].esel);
        end

        // Stall in the middle of a tie: A wins, two stalled cycles, then B.
        drive(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        expect_all("stall_tieA", 1, 0, 0, 5'd9, 32'h99, 1);
        drive(0, 1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        expect_all("stall_c1", 0, 0, 1, 5'd3, 32'h11, 0);
        drive(0, 1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        expect_all("stall_c2", 0, 0, 0, 5'd3, 32'h11, 0);
        drive(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        expect_all("stall_release", 0, 1, 0, 5'd3, 32'h11, 0);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_all("stall_after", 0, 0, 1, 5'd4, 32'h22, 1);

        // Reset right after an A grant: B must not be granted, pointer returns to PREF_A.
        drive(0, 0, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
        expect_all("rstmid_grantA", 1, 0, 0, 5'd4, 32'h22, 1);
        drive(1, 0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h66);
        expect_all("rstmid_reset", 0, 0, 1, 5'd7, 32'h77, 0);
        drive(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        expect_all("rstmid_tie", 1, 0, 0, 5'd0, 32'h0, 0);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_all("rstmid_after", 0, 0, 1, 5'd3, 32'h11, 0);

        // Same destination from both sides on consecutive grants: both writes issue in order.
        drive(0, 0, 1, 5'd12, 32'hA1, 1, 5'd12, 32'hB2);
        expect_all("samedst_1", 0, 1, 0, 5'd3, 32'h11, 0);
        drive(0, 0, 1, 5'd12, 32'hA1, 0, 5'd0, 32'h0);
        expect_all("samedst_2", 1, 0, 1, 5'd12, 32'hB2, 1);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_all("samedst_3", 0, 0, 1, 5'd12, 32'hA1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_wb_port_arbiter
`default_nettype wire
